// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; drains core output to txd.
// Define UART_TX_TWO_STOP_EN for two stop bits (default: one stop bit).
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 30,
    parameter int DEPTH_LOG2       = 6
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        txd,
    input  logic [31:0] send_data,
    input  logic [1:0]  core_sig,
    output logic [31:0] data_count,
    output logic        output_stall,
    output logic        output_ready
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int BW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int PW      = DEPTH_LOG2 + 1;

`ifdef UART_TX_TWO_STOP_EN
    localparam logic TWO_STOP = 1'b1;
`else
    localparam logic TWO_STOP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         count;
    logic [PW-1:0]         free;
    logic [PW-1:0]         needed;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [7:0]            head;
    logic                  empty;
    logic                  push_ok;

    state_t                state;
    state_t                state_n;
    logic [BW-1:0]         baud;
    logic [BW-1:0]         baud_n;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_idx_n;
    logic                  stop_idx;
    logic                  stop_idx_n;
    logic                  baud_end;
    logic                  last_stop;
    logic                  pop;
    logic                  done;
    logic [7:0]            shreg;
    logic                  txd_n;

    assign count        = wptr - rptr;
    assign free         = PW'(DEPTH) - count;
    assign needed       = core_sig[0] ? PW'(4) : PW'(1);
    assign push_ok      = core_sig[1] && (free >= needed);
    assign empty        = (count == '0);
    assign waddr        = wptr[DEPTH_LOG2-1:0];
    assign head         = mem[rptr[DEPTH_LOG2-1:0]];
    assign output_stall = (free < PW'(4));
    assign output_ready = empty && (state == S_IDLE);
    assign baud_end     = (baud == BW'(BIT_CYC - 1));
    assign last_stop    = !TWO_STOP || stop_idx;

    // Storage: a word request writes all four bytes in one cycle, LSB first
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 0 || core_sig[0]) begin
                    mem[waddr + DEPTH_LOG2'(i)] <= send_data[8*i +: 8];
                end
            end
        end
    end

    // Pointers: push advances by the request size, pop by one byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + needed;
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    // FSM state, baud counter and bit/stop indices
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
        end
    end

    // Next-state: frame sequencing; back-to-back frames skip IDLE
    always_comb begin
        state_n    = state;
        baud_n     = baud + BW'(1);
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        pop        = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_n    = '0;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        stop_idx_n = 1'b0;
                        state_n    = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (last_stop) begin
                        done = 1'b1;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Line level for the current state
    always_comb begin
        txd_n = 1'b1;
        unique case (state)
            S_START: txd_n = 1'b0;
            S_DATA:  txd_n = shreg[bit_idx];
            default: txd_n = 1'b1;
        endcase
    end

    // Registered line output keeps txd glitch-free
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txd <= 1'b1;
        end else begin
            txd <= txd_n;
        end
    end

    // Shift register takes the head byte on every pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg <= '0;
        end else if (pop) begin
            shreg <= head;
        end
    end

    // Completed-byte counter, bumped on the final stop cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_count <= '0;
        end else if (done) begin
            data_count <= data_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected bytes queued at push time,
// a UART-decoding monitor pops and compares each received frame.
module tb_uart_tx_fifo;

    localparam int HALF = 4;
    localparam int DL2  = 3;
    localparam int BITC = 2 * HALF;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int STOP_CYC = BITC * NSTOP;
    localparam int FRAME    = BITC * 9 + STOP_CYC;
    localparam int T_END    = 1 + BITC + 8 * BITC + STOP_CYC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] send_data = '0;
    logic [1:0]  core_sig = '0;
    logic        txd;
    logic [31:0] data_count;
    logic        output_stall;
    logic        output_ready;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          rst_evt = 0;
    logic [7:0]  exp_q[$];
    int          starts[$];

    uart_tx_fifo #(
        .CLK_PER_HALF_BIT(HALF),
        .DEPTH_LOG2(DL2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .txd(txd),
        .send_data(send_data),
        .core_sig(core_sig),
        .data_count(data_count),
        .output_stall(output_stall),
        .output_ready(output_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drv(input logic [1:0] cs, input logic [31:0] d);
        core_sig  = cs;
        send_data = d;
    endtask

    task automatic do_reset();
        step(1);
        rstn = 1'b0;
        rst_evt++;
        drv(2'b00, 32'h0);
        step(3);
        rstn = 1'b1;
        step(2);
        starts.delete();
    endtask

    task automatic wait_drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && output_ready) ok = 1'b1;
        end
        chk({nm, "_drain"}, {31'd0, ok}, 32'd1);
        step(20);
    endtask

    // Monitor: decode frames at mid-bit, drop frames cut by reset
    initial begin : monitor
        int         ev;
        int         st;
        logic [7:0] b;
        logic       sb;
        forever begin
            @(negedge clk);
            if (rstn && txd === 1'b0) begin
                ev = rst_evt;
                st = cyc;
                repeat (HALF) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (BITC) @(negedge clk);
                    b[k] = txd;
                end
                repeat (BITC) @(negedge clk);
                sb = txd;
                if (ev == rst_evt) begin
                    starts.push_back(st);
                    chk("stop_bit", {31'd0, sb}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %h required none", b);
                    end else begin
                        chk("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t_fall;
        int t_inc;

        // reset state
        step(2);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_count", data_count, 32'd0);
        chk("rst_stall", {31'd0, output_stall}, 32'd0);
        chk("rst_ready", {31'd0, output_ready}, 32'd1);
        rstn = 1'b1;
        step(2);

        // 1: single byte 0x55, latency and ready
        chk("t1_ready_pre", {31'd0, output_ready}, 32'd1);
        drv(2'b10, 32'h0000_0055);
        exp_q.push_back(8'h55);
        step(1);
        drv(2'b00, 32'h0);
        chk("t1_ready_drop", {31'd0, output_ready}, 32'd0);
        step(1);
        chk("t1_txd_n1", {31'd0, txd}, 32'd1);
        step(1);
        chk("t1_txd_n2", {31'd0, txd}, 32'd0);
        wait_drain("t1");
        chk("t1_count", data_count, 32'd1);
        chk("t1_ready", {31'd0, output_ready}, 32'd1);

        // 2: word, little-endian, back-to-back frames
        do_reset();
        drv(2'b11, 32'hDEAD_BEEF);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hDE);
        step(1);
        drv(2'b00, 32'h0);
        wait_drain("t2");
        chk("t2_count", data_count, 32'd4);
        chk("t2_frames", starts.size(), 32'd4);
        for (int i = 1; i < starts.size(); i++) begin
            chk("t2_gap", starts[i] - starts[i-1], FRAME);
        end

        // 3: fill FIFO, drop word, accept byte at free=1, drop at full
        do_reset();
        chk("t3_stall0", {31'd0, output_stall}, 32'd0);
        drv(2'b11, 32'h1122_3344);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h11);
        step(1);
        chk("t3_stall_a", {31'd0, output_stall}, 32'd0);
        drv(2'b11, 32'h5566_7788);
        exp_q.push_back(8'h88);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h55);
        step(1);
        chk("t3_stall_b", {31'd0, output_stall}, 32'd1);
        drv(2'b11, 32'h99AA_BBCC);
        step(1);
        drv(2'b10, 32'h0000_0012);
        exp_q.push_back(8'h12);
        step(1);
        drv(2'b10, 32'h0000_0034);
        step(1);
        drv(2'b00, 32'h0);
        chk("t3_stall_full", {31'd0, output_stall}, 32'd1);
        chk("t3_ready_full", {31'd0, output_ready}, 32'd0);
        wait_drain("t3");
        chk("t3_count", data_count, 32'd9);

        // 4: push on the last STOP cycle with one byte queued
        do_reset();
        drv(2'b10, 32'h0000_00C3);
        exp_q.push_back(8'hC3);
        step(1);
        drv(2'b00, 32'h0);
        step(4);
        drv(2'b10, 32'h0000_005A);
        exp_q.push_back(8'h5A);
        step(1);
        drv(2'b00, 32'h0);
        step(T_END - 6);
        chk("t4_count_pre", data_count, 32'd0);
        drv(2'b10, 32'h0000_0081);
        exp_q.push_back(8'h81);
        step(1);
        drv(2'b00, 32'h0);
        chk("t4_count_post", data_count, 32'd1);
        chk("t4_ready", {31'd0, output_ready}, 32'd0);
        wait_drain("t4");
        chk("t4_count", data_count, 32'd3);
        chk("t4_frames", starts.size(), 32'd3);
        for (int i = 1; i < starts.size(); i++) begin
            chk("t4_gap", starts[i] - starts[i-1], FRAME);
        end

        // 5: async reset in DATA bit 3
        do_reset();
        drv(2'b10, 32'h0000_003C);
        exp_q.push_back(8'h3C);
        step(1);
        drv(2'b00, 32'h0);
        wait_drain("t5a");
        chk("t5_count_pre", data_count, 32'd1);
        drv(2'b10, 32'h0000_0000);
        step(1);
        drv(2'b10, 32'h0000_00F0);
        step(1);
        drv(2'b00, 32'h0);
        step(36);
        chk("t5_txd_low", {31'd0, txd}, 32'd0);
        rstn = 1'b0;
        rst_evt++;
        #1;
        chk("t5_txd", {31'd0, txd}, 32'd1);
        chk("t5_count", data_count, 32'd0);
        chk("t5_ready", {31'd0, output_ready}, 32'd1);
        chk("t5_stall", {31'd0, output_stall}, 32'd0);
        step(3);
        rstn = 1'b1;
        step(120);
        chk("t5_idle_txd", {31'd0, txd}, 32'd1);
        chk("t5_idle_ready", {31'd0, output_ready}, 32'd1);
        chk("t5_idle_count", data_count, 32'd0);

        // 6: stop length from start edge to counter bump
        do_reset();
        drv(2'b10, 32'h0000_00A5);
        exp_q.push_back(8'hA5);
        step(1);
        drv(2'b00, 32'h0);
        t_fall = -1;
        t_inc  = -1;
        for (int i = 0; i < 500 && t_inc < 0; i++) begin
            if (t_fall < 0 && txd == 1'b0) t_fall = cyc;
            if (t_inc < 0 && data_count != 32'd0) t_inc = cyc;
            step(1);
        end
        chk("t6_stop_len", t_inc - t_fall, 71 + STOP_CYC);
        wait_drain("t6");
        chk("t6_count", data_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
